// File: rtl/typed_arb_pkg.sv
// typed_arb_pkg
//   Shared definitions for the typed round-robin arbiter family.
//   - arb_state_e : output-stage occupancy (EMPTY / FULL)
//   - rr_next     : wrap-around increment of a requester index modulo n
package typed_arb_pkg;

   typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin picker, independent of payload type.
//   Ports:
//     req [N]   : per-requester request bits
//     ptr [IDW] : highest-priority index for this scan (must be < N)
//     win [IDW] : first requesting index found scanning from ptr, wrapping mod N
//     any       : at least one request is present
module rr_picker #(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] win,
   output logic           any
);

   // One extra bit so ptr + offset cannot overflow before the modulo fold.
   localparam int SW = IDW + 1;

   logic [SW-1:0]  sum;
   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      win   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int unsigned off = 0; off < N; off++) begin
         sum = {1'b0, ptr} + SW'(off);
         if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
         end
         cand = sum[IDW-1:0];
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/typed_rr_arbiter.sv
// typed_rr_arbiter
//   Round-robin arbiter sharing one valid/ready sink among N valid/ready
//   producers, with a one-entry registered output stage.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     req_valid [N]     : per-requester valid
//     req_data  [N] x T : per-requester payload
//     req_ready [N]     : one-hot-or-zero accept strobe
//     out_valid         : output register holds a payload
//     out_data  T       : registered payload
//     out_id    [IDW]   : index of the requester that supplied out_data
//     out_ready         : sink accepts when high together with out_valid
module typed_rr_arbiter
   import typed_arb_pkg::*;
#(
   parameter  type T   = logic [31:0],
   parameter  int  N   = 4,
   localparam int  IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   input  T               req_data [N],
   output logic [N-1:0]   req_ready,
   output logic           out_valid,
   output T               out_data,
   output logic [IDW-1:0] out_id,
   input  logic           out_ready
);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic           out_valid_q, out_valid_d;
   T               out_data_q, out_data_d;
   logic [IDW-1:0] out_id_q, out_id_d;

   logic [IDW-1:0] win;
   logic           req_any;
   logic           load;

   rr_picker #(.N(N)) u_picker (
      .req (req_valid),
      .ptr (ptr_q),
      .win (win),
      .any (req_any)
   );

   // Gating with rst keeps req_ready low in the reset cycle, so nothing is
   // accepted and then dropped by the reset.
   always_comb begin
      load      = req_any && (state_q == ARB_EMPTY || out_ready) && !rst;
      req_ready = '0;
      if (load) begin
         req_ready[win] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      if (load) begin
         state_d     = ARB_FULL;
         out_valid_d = 1'b1;
         out_data_d  = req_data[win];
         out_id_d    = win;
         ptr_d       = IDW'(rr_next(32'(win), N));
      end else if (state_q == ARB_FULL && out_ready) begin
         // Drained with nothing to refill: payload/id are left as they were.
         state_d     = ARB_EMPTY;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_EMPTY;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule
